// File: rtl/edl_final_led_pio.sv
// Avalon-MM output PIO driving board LEDs, with a per-bit hardware blink engine.
// Optional macro EDL_LED_PIO_SETCLR_EN enables atomic set/clear writes to address 3.
module edl_final_led_pio #(
  parameter int unsigned      WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int unsigned      PERIOD_W       = 24,
  parameter int unsigned      DEFAULT_PERIOD = 2500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE         = PERIOD_W'(1);

  logic                wr;
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic                phase;
  logic [31:0]         rd_next;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      mask <= '0;
    end else if (wr) begin
      case (address)
        2'd0: data <= writedata[WIDTH-1:0];
        2'd1: mask <= writedata[WIDTH-1:0];
`ifdef EDL_LED_PIO_SETCLR_EN
        2'd3: begin
          if (writedata[31]) data <= data | writedata[WIDTH-1:0];
          else               data <= data & ~writedata[WIDTH-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the half-period and wins over a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= PERIOD_INIT;
      counter <= '0;
      phase   <= 1'b1;
    end else if (wr && address == 2'd2) begin
      period  <= writedata[PERIOD_W-1:0];
      counter <= '0;
      phase   <= 1'b1;
    end else if (period == '0) begin
      counter <= '0;
      phase   <= 1'b1;
    end else if (counter == period - ONE) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + ONE;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0: rd_next[WIDTH-1:0]    = data;
      2'd1: rd_next[WIDTH-1:0]    = mask;
      2'd2: rd_next[PERIOD_W-1:0] = period;
      2'd3: begin
        rd_next[31]           = phase;
        rd_next[PERIOD_W-1:0] = counter;
      end
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= rd_next;
      out_port <= data & (~mask | {WIDTH{phase}});
    end
  end

endmodule

// File: tb/tb_edl_final_led_pio.sv
// Directed self-checking bench for edl_final_led_pio (default parameters).
module tb_edl_final_led_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  edl_final_led_pio #(
    .WIDTH(8),
    .RESET_VALUE(8'h00),
    .PERIOD_W(24),
    .DEFAULT_PERIOD(2500000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] r;
  logic [7:0]  exp_blink_out [12] = '{8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'hFF,
                                      8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'hFF};
  logic [31:0] exp_blink_st  [12] = '{32'h80000002, 32'h0, 32'h1, 32'h2,
                                      32'h80000000, 32'h80000001, 32'h80000002,
                                      32'h0, 32'h1, 32'h2, 32'h80000000, 32'h80000001};
  logic [7:0]  exp_rst_out   [7]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0};
  logic [31:0] exp_rst_st    [7]  = '{32'h80000000, 32'h80000001, 32'h80000002,
                                      32'h80000003, 32'h80000004, 32'h0, 32'h1};

  initial begin
    reset_n    = 1'b0;
    address    = 2'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #2;
    check("reset_out_port", 32'(out_port), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    #20 reset_n = 1'b1;

    // STATUS first so the free-running counter is still 0
    rd(3, r); check("rst_status", r, 32'h80000000);
    rd(0, r); check("rst_data",   r, 32'h0);
    rd(1, r); check("rst_mask",   r, 32'h0);
    rd(2, r); check("rst_period", r, 32'd2500000);

    // plain write: visible one edge after the write edge
    wr(0, 32'h0000005A);
    check("data_not_yet", 32'(out_port), 32'h0);
    tick();
    check("data_out", 32'(out_port), 32'h5A);
    rd(0, r); check("data_read", r, 32'h0000005A);

    // blink with half-period 3 on the low nibble
    wr(2, 32'd3);
    wr(1, 32'h0F);
    wr(0, 32'hFF);
    address = 2'd3;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("blink_out_%0d", i), 32'(out_port), 32'(exp_blink_out[i]));
      check($sformatf("blink_status_%0d", i), readdata, exp_blink_st[i]);
    end

    // counter is at terminal (2) now; PERIOD write must suppress the toggle
    wr(2, 32'd5);
    address = 2'd3;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("prd_restart_out_%0d", i), 32'(out_port), 32'(exp_rst_out[i]));
      check($sformatf("prd_restart_status_%0d", i), readdata, exp_rst_st[i]);
    end

    // PERIOD 0 freezes the blink on
    wr(2, 32'd0);
    wr(1, 32'hFF);
    wr(0, 32'h3C);
    address = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("frozen_out_%0d", i), 32'(out_port), 32'h3C);
      check($sformatf("frozen_status_%0d", i), readdata, 32'h80000000);
    end
    rd(2, r); check("period_zero_read", r, 32'h0);
    rd(1, r); check("mask_read", r, 32'hFF);

    // set/clear via address 3
    wr(1, 32'h0);
    wr(0, 32'h0F);
    wr(3, 32'h80000030);
    rd(0, r);
`ifdef EDL_LED_PIO_SETCLR_EN
    check("setclr_set", r, 32'h3F);
`else
    check("setclr_set_ignored", r, 32'h0F);
`endif
    wr(3, 32'h00000003);
    rd(0, r);
    tick();
`ifdef EDL_LED_PIO_SETCLR_EN
    check("setclr_clr", r, 32'h3C);
    check("setclr_out", 32'(out_port), 32'h3C);
`else
    check("setclr_clr_ignored", r, 32'h0F);
    check("setclr_out_ignored", 32'(out_port), 32'h0F);
`endif

    // upper writedata bits are dropped
    wr(0, 32'hFFFFFF00);
    rd(0, r); check("data_upper_ignored", r, 32'h0);
    wr(2, 32'hFF000007);
    rd(2, r); check("period_upper_ignored", r, 32'h7);

    // asynchronous reset in the middle of a blink
    wr(2, 32'd3);
    wr(1, 32'h0F);
    wr(0, 32'hFF);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_port), 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3, r); check("post_rst_status", r, 32'h80000000);
    rd(0, r); check("post_rst_data",   r, 32'h0);
    rd(1, r); check("post_rst_mask",   r, 32'h0);
    rd(2, r); check("post_rst_period", r, 32'd2500000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
